// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    ADJUST
  } sw_state_t;

  // Adjust-tick strobes per field increment (2 Hz tick -> 1 Hz increment).
  localparam int unsigned ADJ_DIV_DEFAULT = 2;

endpackage

// File: rtl/edge_pulse.sv
// One-bit rising-edge detector on a debounced button level.
// The previous-level register resets to 1, so a button held through reset
// release produces no event until it is released and pressed again.
// The pulse is registered: a press sampled on one edge is visible after it.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  // Track the previous level and flag a 0 -> 1 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: turns debounced button levels into press events,
// holds the IDLE/RUN/PAUSED/ADJUST state machine, divides the adjust tick and
// drives registered run/clear/increment/blink outputs for the time counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned ADJ_DIV = ADJ_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_db,
  input  logic reset_db,
  input  logic adj_sw,
  input  logic sel_sw,
  input  logic adj_tick,
  output logic run_en,
  output logic clear,
  output logic inc_sec,
  output logic inc_min,
  output logic blink_sec,
  output logic blink_min
);

  localparam int unsigned CW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(ADJ_DIV - 1);

  sw_state_t     state, state_nxt;
  logic          pause_ev, reset_ev;
  logic [CW-1:0] div_cnt, div_cnt_nxt;
  logic          inc_sec_nxt, inc_min_nxt;

  edge_pulse u_pause_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (pause_db),
    .pulse (pause_ev)
  );

  edge_pulse u_reset_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (reset_db),
    .pulse (reset_ev)
  );

  // Next-state: adjust switch dominates, then reset press, then pause press.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ADJUST: begin
        if (!adj_sw) state_nxt = PAUSED;
      end
      default: begin
        if (adj_sw)        state_nxt = ADJUST;
        else if (reset_ev) state_nxt = IDLE;
        else if (pause_ev) state_nxt = (state == RUN) ? PAUSED : RUN;
      end
    endcase
  end

  // Adjust divider: counts ticks only while in ADJUST, held at zero otherwise
  // so every ADJUST entry starts a fresh divide.
  always_comb begin
    div_cnt_nxt = div_cnt;
    inc_sec_nxt = 1'b0;
    inc_min_nxt = 1'b0;
    if (state != ADJUST) begin
      div_cnt_nxt = '0;
    end else if (adj_tick) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt_nxt = '0;
        inc_sec_nxt = ~sel_sw;
        inc_min_nxt = sel_sw;
      end else begin
        div_cnt_nxt = div_cnt + 1'b1;
      end
    end
  end

  // State, divider and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      run_en    <= 1'b0;
      clear     <= 1'b0;
      inc_sec   <= 1'b0;
      inc_min   <= 1'b0;
      blink_sec <= 1'b0;
      blink_min <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_cnt_nxt;
      run_en    <= (state_nxt == RUN);
      clear     <= reset_ev;
      inc_sec   <= inc_sec_nxt;
      inc_min   <= inc_min_nxt;
      blink_sec <= (state_nxt == ADJUST) & ~sel_sw;
      blink_min <= (state_nxt == ADJUST) & sel_sw;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios against fixed
// expectations plus a randomized run against a behavioural reference model.
module tb_stopwatch_ctrl;

  localparam int unsigned ADJ_DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_db = 1'b0, reset_db = 1'b0, adj_sw = 1'b0, sel_sw = 1'b0, adj_tick = 1'b0;
  logic run_en, clear, inc_sec, inc_min, blink_sec, blink_min;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.ADJ_DIV(ADJ_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pause_db  (pause_db),
    .reset_db  (reset_db),
    .adj_sw    (adj_sw),
    .sel_sw    (sel_sw),
    .adj_tick  (adj_tick),
    .run_en    (run_en),
    .clear     (clear),
    .inc_sec   (inc_sec),
    .inc_min   (inc_min),
    .blink_sec (blink_sec),
    .blink_min (blink_min)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Mode numbers are the bench's own; events seen on one edge act on the next.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_ADJ = 3;
  int  m_mode;
  int  m_ticks;
  bit  m_prev_p, m_prev_r, m_ev_p, m_ev_r;
  bit  e_run, e_clr, e_is, e_im, e_bs, e_bm;

  always @(posedge clk or negedge rst_n) begin
    bit pev, rev;
    if (!rst_n) begin
      m_mode = M_IDLE; m_ticks = 0;
      m_prev_p = 1; m_prev_r = 1; m_ev_p = 0; m_ev_r = 0;
      {e_run, e_clr, e_is, e_im, e_bs, e_bm} = '0;
    end else begin
      pev = m_ev_p; rev = m_ev_r;
      m_ev_p = pause_db && !m_prev_p;
      m_ev_r = reset_db && !m_prev_r;
      m_prev_p = pause_db; m_prev_r = reset_db;
      e_is = 0; e_im = 0;
      if (m_mode == M_ADJ) begin
        if (adj_tick) begin
          m_ticks++;
          if (m_ticks == int'(ADJ_DIV)) begin
            m_ticks = 0;
            if (sel_sw) e_im = 1; else e_is = 1;
          end
        end
      end else m_ticks = 0;
      e_clr = rev;
      if (m_mode == M_ADJ)  m_mode = adj_sw ? M_ADJ : M_PAUSED;
      else if (adj_sw)      m_mode = M_ADJ;
      else if (rev)         m_mode = M_IDLE;
      else if (pev)         m_mode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
      e_run = (m_mode == M_RUN);
      e_bs  = (m_mode == M_ADJ) && !sel_sw;
      e_bm  = (m_mode == M_ADJ) && sel_sw;
    end
  end

  // ---------------- scenarios ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(2);
    checks++;
    if ({run_en, clear, inc_sec, inc_min, blink_sec, blink_min} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold outs=%b want=000000", {run_en, clear, inc_sec, inc_min, blink_sec, blink_min});
    end
    rst_n = 1'b1;
    cycles(2);
    checks++;
    if ({run_en, clear, inc_sec, inc_min, blink_sec, blink_min} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release outs=%b want=000000", {run_en, clear, inc_sec, inc_min, blink_sec, blink_min});
    end
  endtask

  task automatic test_pause();
    logic want;
    for (int p = 0; p < 3; p++) begin
      want = (p != 1);
      pause_db = 1'b1;
      cycles(1);
      checks++;
      if (run_en !== !want) begin
        errors++;
        $display("FAIL pause%0d_latency run_en=%b want=%b", p, run_en, !want);
      end
      cycles(1);
      checks++;
      if (run_en !== want) begin
        errors++;
        $display("FAIL pause%0d_toggle run_en=%b want=%b", p, run_en, want);
      end
      cycles(3);
      pause_db = 1'b0;
      cycles(2);
      checks++;
      if (run_en !== want) begin
        errors++;
        $display("FAIL pause%0d_hold run_en=%b want=%b", p, run_en, want);
      end
    end
  endtask

  task automatic test_reset_press();
    int nclr = 0;
    reset_db = 1'b1; pause_db = 1'b1;
    cycles(1);
    checks++;
    if (clear !== 1'b0) begin
      errors++;
      $display("FAIL clear_early clear=%b want=0", clear);
    end
    cycles(1);
    checks++;
    if ({clear, run_en} !== 2'b10) begin
      errors++;
      $display("FAIL clear_pulse clear,run_en=%b want=10", {clear, run_en});
    end
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (clear) nclr++;
    end
    checks++;
    if (nclr != 0 || run_en !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold extra_clears=%0d run_en=%b want 0/0", nclr, run_en);
    end
    reset_db = 1'b0; pause_db = 1'b0;
    cycles(2);
  endtask

  task automatic test_hold_through_reset();
    int nrun = 0;
    pause_db = 1'b1;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      if (run_en) nrun++;
    end
    checks++;
    if (nrun != 0) begin
      errors++;
      $display("FAIL held_pause run_cycles=%0d want=0", nrun);
    end
    pause_db = 1'b0;
    cycles(2);
    pause_db = 1'b1;
    cycles(2);
    checks++;
    if (run_en !== 1'b1) begin
      errors++;
      $display("FAIL repress_after_hold run_en=%b want=1", run_en);
    end
    pause_db = 1'b0;
    cycles(1);
  endtask

  task automatic test_adjust();
    int ns = 0, nm = 0;
    adj_sw = 1'b1; sel_sw = 1'b0;
    cycles(1);
    checks++;
    if ({run_en, blink_sec, blink_min} !== 3'b010) begin
      errors++;
      $display("FAIL adj_entry run,bs,bm=%b want=010", {run_en, blink_sec, blink_min});
    end
    for (int t = 0; t < 6; t++) begin
      adj_tick = 1'b1;
      cycles(1);
      ns += int'(inc_sec); nm += int'(inc_min);
      adj_tick = 1'b0;
      cycles(1);
      ns += int'(inc_sec); nm += int'(inc_min);
    end
    checks++;
    if (ns != 3 || nm != 0) begin
      errors++;
      $display("FAIL adj_sec inc_sec=%0d inc_min=%0d want 3/0", ns, nm);
    end
    sel_sw = 1'b1;
    ns = 0; nm = 0;
    cycles(1);
    checks++;
    if ({blink_sec, blink_min} !== 2'b01) begin
      errors++;
      $display("FAIL adj_sel bs,bm=%b want=01", {blink_sec, blink_min});
    end
    for (int t = 0; t < 2; t++) begin
      adj_tick = 1'b1;
      cycles(1);
      ns += int'(inc_sec); nm += int'(inc_min);
      adj_tick = 1'b0;
      cycles(1);
      ns += int'(inc_sec); nm += int'(inc_min);
    end
    checks++;
    if (ns != 0 || nm != 1) begin
      errors++;
      $display("FAIL adj_min inc_sec=%0d inc_min=%0d want 0/1", ns, nm);
    end
  endtask

  task automatic test_adjust_reset();
    reset_db = 1'b1;
    cycles(2);
    checks++;
    if ({clear, blink_min, run_en} !== 3'b110) begin
      errors++;
      $display("FAIL adj_clear clr,bm,run=%b want=110", {clear, blink_min, run_en});
    end
    reset_db = 1'b0;
    cycles(1);
    adj_sw = 1'b0;
    cycles(1);
    checks++;
    if ({clear, blink_sec, blink_min, run_en} !== 4'b0000) begin
      errors++;
      $display("FAIL adj_exit clr,bs,bm,run=%b want=0000", {clear, blink_sec, blink_min, run_en});
    end
    pause_db = 1'b1;
    cycles(2);
    checks++;
    if (run_en !== 1'b1) begin
      errors++;
      $display("FAIL paused_resume run_en=%b want=1", run_en);
    end
    pause_db = 1'b0;
    sel_sw = 1'b0;
    cycles(1);
  endtask

  task automatic test_async_reset();
    checks++;
    if (run_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_async run_en=%b want=1", run_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({run_en, clear, inc_sec, inc_min, blink_sec, blink_min} !== 6'b0) begin
      errors++;
      $display("FAIL async_drop outs=%b want=000000", {run_en, clear, inc_sec, inc_min, blink_sec, blink_min});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    checks++;
    if ({run_en, clear, inc_sec, inc_min, blink_sec, blink_min} !== 6'b0) begin
      errors++;
      $display("FAIL async_release outs=%b want=000000", {run_en, clear, inc_sec, inc_min, blink_sec, blink_min});
    end
    pause_db = 1'b1;
    cycles(2);
    checks++;
    if (run_en !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_async run_en=%b want=1", run_en);
    end
    pause_db = 1'b0;
    cycles(1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if ({run_en, clear, inc_sec, inc_min, blink_sec, blink_min} !==
          {e_run, e_clr, e_is, e_im, e_bs, e_bm}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cyc%0d outs=%b want=%b", i,
                   {run_en, clear, inc_sec, inc_min, blink_sec, blink_min},
                   {e_run, e_clr, e_is, e_im, e_bs, e_bm});
        bad++;
      end
      if ($urandom_range(3) == 0)  pause_db = ~pause_db;
      if ($urandom_range(7) == 0)  reset_db = ~reset_db;
      if ($urandom_range(24) == 0) adj_sw   = ~adj_sw;
      if ($urandom_range(9) == 0)  sel_sw   = ~sel_sw;
      adj_tick = ($urandom_range(2) == 0);
    end
    pause_db = 0; reset_db = 0; adj_sw = 0; sel_sw = 0; adj_tick = 0;
  endtask

  initial begin
    test_reset();
    test_pause();
    test_reset_press();
    test_hold_through_reset();
    test_adjust();
    test_adjust_reset();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
